img_writer: RTL and testbench
=============================

IMG_WRITER -- requirements
Module: img_writer

Interface
REQ-001 SHALL have parameter H_RES, default 170, pixels per line.
REQ-002 SHALL have parameter V_RES, default 240, lines per frame.
REQ-003 SHALL have parameter DATA_W, default 8, pixel width.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 4096, idle-cycle limit for abort.
REQ-005 SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port i_start  input  1  one-cycle pulse that arms capture of the next frame.
REQ-008 SHALL have port i_de  input  1  pixel-valid strobe from the processing pipeline.
REQ-009 SHALL have port i_data  input  DATA_W  pixel value, sampled when i_de=1.
REQ-010 SHALL have port we  output  1  result-RAM write enable.
REQ-011 SHALL have port waddr  output  16  result-RAM write address.
REQ-012 SHALL have port wdata  output  DATA_W  result-RAM write data.
REQ-013 SHALL have port o_busy  output  1  high while in ARMED or CAPTURE.
REQ-014 SHALL have port o_frame_done  output  1  one-cycle pulse after the last pixel is written.
REQ-015 SHALL have port o_overflow  output  1  sticky flag for a stray pixel.
REQ-016 SHALL have port o_abort  output  1  one-cycle pulse on timeout abort.

Function
REQ-017 SHALL implement the states IDLE, ARMED, CAPTURE and DONE.
REQ-018 SHALL move IDLE->ARMED on i_start; i_start in any other state SHALL be ignored.
REQ-019 SHALL move ARMED->CAPTURE on the first i_de=1 and write that pixel at address 0.
REQ-020 SHALL hold x (0..H_RES-1) and y (0..V_RES-1) counters; x wraps to 0 and increments y at H_RES-1.
REQ-021 SHALL compute waddr = y*H_RES + x, giving 0..40799 at the default parameters.
REQ-022 SHALL register we/waddr/wdata, so a pixel sampled at cycle N appears with we=1 at cycle N+1.
REQ-023 SHALL drive we=0 and hold waddr/wdata at their last values on every cycle without i_de.
REQ-024 SHALL tolerate gaps in i_de: the counters advance only on i_de=1.
REQ-025 SHALL move CAPTURE->DONE when it samples pixel (H_RES-1, V_RES-1), clearing both counters.
REQ-026 SHALL assert o_frame_done for exactly one cycle in DONE, which is the cycle after we=1 for the last pixel, then go DONE->IDLE.
REQ-027 SHALL set o_overflow when i_de=1 in IDLE or DONE, write nothing, and clear o_overflow only on the next accepted i_start.

Reset
REQ-028 SHALL asynchronously force, on reset=1: state=IDLE, x=y=0, we=0, waddr=0, wdata=0, o_busy=0, o_frame_done=0, o_overflow=0, o_abort=0.
REQ-029 SHALL treat reset mid-CAPTURE as an abandoned frame: no o_frame_done pulse, and a new i_start is required.

Configuration
REQ-030 SHALL, with IMG_WRITER_TIMEOUT_EN defined, count consecutive cycles in CAPTURE with i_de=0.
REQ-031 SHALL, when that count reaches TIMEOUT_CYC, go to IDLE, pulse o_abort for one cycle, clear the counters, and suppress o_frame_done.
REQ-032 SHALL reset the idle counter on every i_de=1.
REQ-033 SHALL, without IMG_WRITER_TIMEOUT_EN, build no idle counter, tie o_abort to 0, and wait in CAPTURE indefinitely.

Structure
REQ-034 SHALL place the state enum (IDLE/ARMED/CAPTURE/DONE) and default resolution constants (170, 240, pixel count 40800) in the shared package img_pkg.
REQ-035 SHALL have one sub-module, img_xy_counter, holding the x/y counters with wrap and a last-pixel flag.

Verification
REQ-036 SHALL cover a full frame: i_start, then 40800 back-to-back i_de with data=addr[7:0] -> 40800 writes at waddr 0..40799, with o_frame_done one cycle after the write to 40799.
REQ-037 SHALL cover gapped input: i_de high 1 of every 3 cycles -> writes at consecutive addresses with no skips, and waddr=170 on the first pixel of line 1.
REQ-038 SHALL cover a stray pixel: i_de=1 while IDLE -> no write and o_overflow=1; the next i_start -> o_overflow=0.
REQ-039 SHALL cover reset mid-frame: reset at pixel 1000 -> all outputs 0 immediately, with no o_frame_done.
REQ-040 SHALL cover timeout with IMG_WRITER_TIMEOUT_EN and TIMEOUT_CYC=16: 500 pixels, then 16 idle cycles -> o_abort pulse, state IDLE, no o_frame_done.
REQ-041 SHALL cover i_start during CAPTURE: pulse at pixel 200 -> ignored, and the frame completes normally at 40800 pixels.

Source files
------------

// File: rtl/img_pkg.sv
// Shared types and default geometry for the frame-capture writer (img_writer).
package img_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int DEF_H_RES  = 170;
  localparam int DEF_V_RES  = 240;
  localparam int DEF_PIXELS = DEF_H_RES * DEF_V_RES;  // 40800
  localparam int ADDR_W     = 16;

  // Counter width that still works for a degenerate 1-wide dimension.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/img_writer_if.sv
// Pixel-stream input and result-RAM write port of img_writer.
// Handshake: i_de and we are valid strobes with no ready. The writer always
// accepts i_de, and the RAM always accepts we. Both sides sample on the same rising edge.
interface img_writer_if
  import img_pkg::*;
#(
  parameter int DATA_W = 8
);

  logic              i_start;
  logic              i_de;
  logic [DATA_W-1:0] i_data;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  modport master (
    input  i_start, i_de, i_data,
    output we, waddr, wdata
  );

  modport slave (
    output i_start, i_de, i_data,
    input  we, waddr, wdata
  );

endinterface

// File: rtl/img_xy_counter.sv
// Raster x/y position counters for img_writer.
// x wraps at H_RES-1 and carries into y. last flags the final pixel of the frame.
module img_xy_counter #(
  parameter int H_RES = 170,
  parameter int V_RES = 240,
  parameter int X_W   = 8,
  parameter int Y_W   = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clr,
  input  logic           adv,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  logic x_end;
  logic y_end;

  assign x_end = (x == X_W'(H_RES - 1));
  assign y_end = (y == Y_W'(V_RES - 1));
  assign last  = x_end && y_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (adv) begin
      if (x_end) begin
        x <= '0;
        y <= y_end ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/img_writer.sv
// Frame capture writer: arms on i_start and writes one frame of i_de pixels to RAM in raster order.
// Optional idle-timeout abort is built only when IMG_WRITER_TIMEOUT_EN is defined.
module img_writer
  import img_pkg::*;
#(
  parameter int H_RES       = DEF_H_RES,
  parameter int V_RES       = DEF_V_RES,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                clk,
  input  logic                reset,
  img_writer_if.master        bus,
  output logic                o_busy,
  output logic                o_frame_done,
  output logic                o_overflow,
  output logic                o_abort,
  output state_t              o_state
);

  localparam int X_W = cnt_w(H_RES);
  localparam int Y_W = cnt_w(V_RES);

  if (TIMEOUT_CYC < 1 || H_RES * V_RES > 65536) begin : g_param_check
    $error("img_writer: bad TIMEOUT_CYC or frame larger than the 16-bit address space");
  end

  state_t            state;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic              last;
  logic              accept;
  logic              timeout_hit;
  logic              cnt_clr;
  logic [ADDR_W-1:0] lin_addr;

  assign accept   = bus.i_de && (state == ARMED || state == CAPTURE);
  assign cnt_clr  = (accept && last) || timeout_hit;
  assign lin_addr = ADDR_W'(32'(y) * 32'(H_RES) + 32'(x));
  assign o_state  = state;

  img_xy_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .X_W   (X_W),
    .Y_W   (Y_W)
  ) u_xy (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .adv   (accept),
    .x     (x),
    .y     (y),
    .last  (last)
  );

`ifdef IMG_WRITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] idle_cnt;
  logic             abort_q;

  // idle_cnt holds the number of idle CAPTURE cycles already seen. The current idle cycle is the one that fires.
  assign timeout_hit = (state == CAPTURE) && !bus.i_de &&
                       (idle_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign o_abort     = abort_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
      abort_q  <= 1'b0;
    end else begin
      abort_q <= timeout_hit;
      if (state != CAPTURE || bus.i_de || timeout_hit) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign o_abort     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      bus.we       <= 1'b0;
      bus.waddr    <= '0;
      bus.wdata    <= '0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      bus.we       <= 1'b0;
      o_frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.i_start) begin
            state      <= ARMED;
            o_busy     <= 1'b1;
            o_overflow <= 1'b0;
          end else if (bus.i_de) begin
            o_overflow <= 1'b1;
          end
        end
        ARMED, CAPTURE: begin
          if (bus.i_de) begin
            bus.we    <= 1'b1;
            bus.waddr <= lin_addr;
            bus.wdata <= bus.i_data;
            if (last) begin
              state  <= DONE;
              o_busy <= 1'b0;
            end else begin
              state <= CAPTURE;
            end
          end else if (timeout_hit) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        DONE: begin
          // DONE spans the last write's cycle and then the frame_done cycle.
          if (bus.i_de) o_overflow <= 1'b1;
          if (!o_frame_done) begin
            o_frame_done <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_img_writer.sv
// Self-checking bench for img_writer: a linear-ordinal reference model feeds an expected-write queue.
// The timeout scenario follows IMG_WRITER_TIMEOUT_EN.
module tb_img_writer;
  import img_pkg::*;

  localparam int H   = 170;
  localparam int V   = 240;
  localparam int PIX = H * V;
  localparam int DW  = 8;
  localparam int TO  = 16;

  logic   clk = 1'b0;
  logic   reset;
  logic   o_busy, o_frame_done, o_overflow, o_abort;
  state_t o_state;

  img_writer_if #(.DATA_W(DW)) bus ();

  img_writer #(
    .H_RES(H), .V_RES(V), .DATA_W(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_overflow   (o_overflow),
    .o_abort      (o_abort),
    .o_state      (o_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model + scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  logic [16+DW-1:0] exp_q[$];
  logic [16+DW-1:0] mon_exp;
  int  m_count    = 0;  // pixels accepted so far in the current frame == next address
  bit  m_active   = 0;  // a frame is armed or being captured
  bit  m_overflow = 0;

  int     wr_cnt = 0, fd_cnt = 0, fd_cyc = -1, last_wr_cyc = -1;
  state_t fd_state;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.we) begin
        wr_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL write_unexpected: got addr=%0d data=%0h, required no write", bus.waddr, bus.wdata);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({bus.waddr, bus.wdata} !== mon_exp) begin
            failures++;
            $display("FAIL write_value: got addr=%0d data=%0h, required addr=%0d data=%0h",
                     bus.waddr, bus.wdata, mon_exp[16+DW-1:DW], mon_exp[DW-1:0]);
          end
        end
        if (bus.waddr == 16'(PIX - 1)) last_wr_cyc = cyc;
      end
      if (o_frame_done) begin
        fd_cnt++;
        fd_cyc   = cyc;
        fd_state = o_state;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_pixel(input logic [DW-1:0] d);
    bus.i_de   = 1'b1;
    bus.i_data = d;
    if (m_active) begin
      exp_q.push_back({16'(m_count), d});
      m_count++;
      if (m_count == PIX) begin
        m_active = 0;
        m_count  = 0;
      end
    end else begin
      m_overflow = 1;
    end
    step();
    bus.i_de   = 1'b0;
    bus.i_data = DW'($urandom);
  endtask

  task automatic pulse_start();
    bus.i_start = 1'b1;
    if (!m_active) begin
      m_active   = 1;
      m_overflow = 0;
    end
    step();
    bus.i_start = 1'b0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_active   = 0;
    m_count    = 0;
    m_overflow = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_reset();
    idle(2);
    reset = 1'b0;
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++; if (bus.we !== 1'b0) begin failures++; $display("FAIL reset_we: got %b required 0", bus.we); end
    checks++; if (bus.waddr !== 16'd0) begin failures++; $display("FAIL reset_waddr: got %0d required 0", bus.waddr); end
    checks++; if (bus.wdata !== '0) begin failures++; $display("FAIL reset_wdata: got %0h required 0", bus.wdata); end
    checks++; if ({o_busy, o_frame_done, o_overflow, o_abort} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags: got %b required 0000", {o_busy, o_frame_done, o_overflow, o_abort});
    end
    checks++; if (o_state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d required %0d", o_state, IDLE); end
  endtask

  task automatic test_full_frame();
    int fd0, wr0;
    fd0 = fd_cnt;
    wr0 = wr_cnt;
    pulse_start();
    checks++; if ({o_busy, o_state} !== {1'b1, ARMED}) begin
      failures++; $display("FAIL armed: got busy=%b state=%0d required busy=1 state=%0d", o_busy, o_state, ARMED);
    end
    for (int i = 0; i < PIX; i++) begin
      if (i == 200) bus.i_start = 1'b1;
      send_pixel(DW'(i));
      bus.i_start = 1'b0;
      if (i == 0) begin
        checks++; if (o_state !== CAPTURE) begin failures++; $display("FAIL capture_entry: got %0d required %0d", o_state, CAPTURE); end
      end
    end
    idle(3);
    checks++; if (fd_cnt - fd0 !== 1) begin failures++; $display("FAIL frame_done_count: got %0d required 1", fd_cnt - fd0); end
    checks++; if (fd_cyc !== last_wr_cyc + 1) begin
      failures++; $display("FAIL frame_done_timing: got cycle %0d required %0d", fd_cyc, last_wr_cyc + 1);
    end
    checks++; if (fd_state !== DONE) begin failures++; $display("FAIL frame_done_state: got %0d required %0d", fd_state, DONE); end
    checks++; if (wr_cnt - wr0 !== PIX) begin failures++; $display("FAIL frame_writes: got %0d required %0d", wr_cnt - wr0, PIX); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL frame_missing: got %0d pending required 0", exp_q.size()); end
    checks++; if ({o_busy, o_state} !== {1'b0, IDLE}) begin
      failures++; $display("FAIL frame_end_idle: got busy=%b state=%0d required busy=0 state=%0d", o_busy, o_state, IDLE);
    end
  endtask

  task automatic test_gapped();
    pulse_start();
    for (int i = 0; i < 400; i++) begin
      send_pixel(DW'($urandom));
      if (i == H) begin
        checks++; if ({bus.we, bus.waddr} !== {1'b1, 16'(H)}) begin
          failures++; $display("FAIL gap_line1_addr: got we=%b addr=%0d required we=1 addr=%0d", bus.we, bus.waddr, H);
        end
      end
      idle(2);
      if (i == H) begin
        checks++; if ({bus.we, bus.waddr} !== {1'b0, 16'(H)}) begin
          failures++; $display("FAIL gap_hold: got we=%b addr=%0d required we=0 addr=%0d", bus.we, bus.waddr, H);
        end
      end
    end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL gap_missing: got %0d pending required 0", exp_q.size()); end
    checks++; if ({o_busy, o_state} !== {1'b1, CAPTURE}) begin
      failures++; $display("FAIL gap_state: got busy=%b state=%0d required busy=1 state=%0d", o_busy, o_state, CAPTURE);
    end
    apply_reset();
  endtask

  task automatic test_reset_mid_frame();
    int fd0;
    fd0 = fd_cnt;
    pulse_start();
    for (int i = 0; i < 1000; i++) send_pixel(DW'($urandom));
    checks++; if (bus.we !== 1'b1) begin failures++; $display("FAIL mid_write_live: got we=%b required 1", bus.we); end
    reset = 1'b1;
    model_reset();
    #1;
    checks++; if ({bus.we, bus.waddr, bus.wdata} !== '0) begin
      failures++; $display("FAIL mid_reset_bus: got we=%b addr=%0d data=%0h required all 0", bus.we, bus.waddr, bus.wdata);
    end
    checks++; if ({o_busy, o_frame_done, o_overflow, o_abort, o_state} !== {4'b0000, IDLE}) begin
      failures++; $display("FAIL mid_reset_flags: got busy/fd/ovf/abort=%b state=%0d required 0000 state=%0d",
                           {o_busy, o_frame_done, o_overflow, o_abort}, o_state, IDLE);
    end
    step();
    reset = 1'b0;
    idle(4);
    checks++; if (fd_cnt !== fd0) begin failures++; $display("FAIL mid_no_done: got %0d pulses required 0", fd_cnt - fd0); end
    send_pixel(DW'($urandom));
    checks++; if ({o_overflow, o_state} !== {m_overflow, IDLE}) begin
      failures++; $display("FAIL mid_needs_start: got ovf=%b state=%0d required ovf=%b state=%0d", o_overflow, o_state, m_overflow, IDLE);
    end
  endtask

  task automatic test_stray();
    apply_reset();
    send_pixel(DW'($urandom));
    checks++; if ({o_overflow, bus.we} !== {m_overflow, 1'b0}) begin
      failures++; $display("FAIL stray_flag: got ovf=%b we=%b required ovf=%b we=0", o_overflow, bus.we, m_overflow);
    end
    idle(5);
    checks++; if (o_overflow !== m_overflow) begin failures++; $display("FAIL stray_sticky: got %b required %b", o_overflow, m_overflow); end
    pulse_start();
    checks++; if ({o_overflow, o_state} !== {m_overflow, ARMED}) begin
      failures++; $display("FAIL stray_clear: got ovf=%b state=%0d required ovf=%b state=%0d", o_overflow, o_state, m_overflow, ARMED);
    end
    apply_reset();
  endtask

  task automatic test_timeout();
    int fd0;
    fd0 = fd_cnt;
    pulse_start();
    for (int i = 0; i < 500; i++) send_pixel(DW'($urandom));
    for (int i = 0; i < TO - 1; i++) begin
      step();
      checks++; if ({o_abort, o_state} !== {1'b0, CAPTURE}) begin
        failures++; $display("FAIL timeout_early: idle %0d got abort=%b state=%0d required abort=0 state=%0d", i + 1, o_abort, o_state, CAPTURE);
      end
    end
    step();
`ifdef IMG_WRITER_TIMEOUT_EN
    m_active = 0;
    m_count  = 0;
    checks++; if ({o_abort, o_busy, o_state} !== {1'b1, 1'b0, IDLE}) begin
      failures++; $display("FAIL timeout_abort: got abort=%b busy=%b state=%0d required abort=1 busy=0 state=%0d", o_abort, o_busy, o_state, IDLE);
    end
    step();
    checks++; if (o_abort !== 1'b0) begin failures++; $display("FAIL timeout_pulse_width: got %b required 0", o_abort); end
    pulse_start();
    send_pixel(DW'($urandom));
    idle(2);
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL timeout_restart: got %0d pending required 0", exp_q.size()); end
`else
    checks++; if ({o_abort, o_state} !== {1'b0, CAPTURE}) begin
      failures++; $display("FAIL no_timeout: got abort=%b state=%0d required abort=0 state=%0d", o_abort, o_state, CAPTURE);
    end
    idle(100);
    checks++; if ({o_abort, o_busy, o_state} !== {1'b0, 1'b1, CAPTURE}) begin
      failures++; $display("FAIL no_timeout_wait: got abort=%b busy=%b state=%0d required abort=0 busy=1 state=%0d", o_abort, o_busy, o_state, CAPTURE);
    end
`endif
    checks++; if (fd_cnt !== fd0) begin failures++; $display("FAIL timeout_no_done: got %0d pulses required 0", fd_cnt - fd0); end
    apply_reset();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset       = 1'b1;
    bus.i_start = 1'b0;
    bus.i_de    = 1'b0;
    bus.i_data  = '0;
    idle(3);
    test_reset();
    reset = 1'b0;
    step();
    test_full_frame();
    test_gapped();
    test_reset_mid_frame();
    test_stray();
    test_timeout();
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL final_queue: got %0d pending required 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
